dna_word_packer: RTL and testbench

Upstream stage of the weighted-syndrome datapath. It collects a serial stream of 2-bit DNA bases, one per accepted handshake, and packs each group of N bases into a 2N-bit word. It presents each word on a valid/ready output whose data feeds the syndrome calculator's `word_in`. A one-word assembly buffer plus one output register let the block absorb downstream stalls without losing bases.

---
 rtl/dna_word_packer.sv | 112 +++++++++++
 tb/tb_dna_word_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dna_word_packer.sv
// Packs a serial stream of 2-bit DNA bases into 2N-bit words, digit 0 in the LSBs.
// Latency: a word is valid on word_out one cycle after its N-th base is accepted.
// Backpressure: holds one word in word_out plus one in the assembly buffer; base_ready drops only when both are full.
// Optional feature: define DNA_PACK_FLUSH_EN to add a flush input that closes a partial word.
module dna_word_packer #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     base_in,
    input  logic           base_valid,
    output logic           base_ready,
`ifdef DNA_PACK_FLUSH_EN
    input  logic           flush,
`endif
    output logic [2*N-1:0] word_out,
    output logic           word_valid,
    input  logic           word_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] asm_q, asm_d;
    logic           asm_full_q, asm_full_d;
    logic [2*N-1:0] word_out_q, word_out_d;
    logic           word_valid_q, word_valid_d;

    logic           accept;
    logic           slot_free;
    logic           complete;
    logic           close_partial;
    logic [2*N-1:0] merged;

    assign base_ready = !asm_full_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;

    // Next-state logic: pack incoming bases, move finished words toward the output register
    always_comb begin
        cnt_d         = cnt_q;
        asm_d         = asm_q;
        asm_full_d    = asm_full_q;
        word_out_d    = word_out_q;
        word_valid_d  = word_valid_q;

        accept    = base_valid && !asm_full_q;
        slot_free = !word_valid_q || word_ready;

        // Assembly content with this cycle's base dropped into its digit slot.
        merged = asm_q;
        if (accept) begin
            merged[2*int'(cnt_q) +: 2] = base_in;
        end

        complete = accept && (cnt_q == LAST);

`ifdef DNA_PACK_FLUSH_EN
        // A coincident base is packed first, so a flush on the first base of a
        // word still closes a one-digit word; unwritten digits stay 00.
        close_partial = flush && !asm_full_q && !complete && ((cnt_q != '0) || accept);
`else
        close_partial = 1'b0;
`endif

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (asm_full_q) begin
            // No base can be accepted while the buffer is full; just drain it when possible.
            if (slot_free) begin
                word_out_d   = asm_q;
                word_valid_d = 1'b1;
                asm_full_d   = 1'b0;
                asm_d        = '0;
            end
        end else if (complete || close_partial) begin
            cnt_d = '0;
            if (slot_free) begin
                word_out_d   = merged;
                word_valid_d = 1'b1;
                asm_d        = '0;
            end else begin
                asm_d      = merged;
                asm_full_d = 1'b1;
            end
        end else if (accept) begin
            asm_d = merged;
            cnt_d = CW'(cnt_q + 1'b1);
        end
    end

    // State registers with asynchronous reset; a reset discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            asm_full_q   <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            asm_full_q   <= asm_full_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: tb/tb_dna_word_packer.sv
// Randomized bench for dna_word_packer against a queue-based reference model.
// Model: accepted bases collect in a list; every N bases form a word appended to an
// expected-word queue, which also predicts word_valid, word_out and base_ready.
module tb_dna_word_packer;

    localparam int N = 6;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   base_in;
    logic         base_valid;
    logic         base_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         flush;

    int vectors = 0;
    int errors  = 0;
    int words   = 0;
    int n_acc   = 0;
    int br_low  = 0;
    logic [W-1:0] last_word = '0;

    logic [1:0]   part[$];
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dna_word_packer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .base_in    (base_in),
        .base_valid (base_valid),
        .base_ready (base_ready),
`ifdef DNA_PACK_FLUSH_EN
        .flush      (flush),
`endif
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word from a list of bases: base k contributes base*4^k.
    function automatic logic [W-1:0] pack(input logic [1:0] b[$]);
        logic [W-1:0] w = '0;
        for (int k = 0; k < b.size(); k++) begin
            w = w + (W'(b[k]) << (2 * k));
        end
        return w;
    endfunction

    // One clock cycle: drive inputs, check DUT against the model, advance the model.
    task automatic cyc(input logic bv, input logic [1:0] b, input logic wr, input logic fl);
        logic acc;
        logic fl_ok;
        int   held;
        @(negedge clk);
        base_valid = bv;
        base_in    = b;
        word_ready = wr;
        flush      = fl;
        #1;
        held = exp_q.size();
        chk("word_valid", word_valid, held > 0);
        chk("base_ready", base_ready, held < 2);
        if (held > 0) chk("word_out", word_out, exp_q[0]);
        if (!base_ready) br_low++;
        acc = bv && (held < 2);
`ifdef DNA_PACK_FLUSH_EN
        fl_ok = fl && (held < 2);
`else
        fl_ok = 1'b0;
`endif
        if (held > 0 && wr) begin
            last_word = word_out;
            void'(exp_q.pop_front());
            words++;
        end
        if (acc) begin
            part.push_back(b);
            n_acc++;
        end
        if (part.size() == N || (fl_ok && part.size() > 0)) begin
            exp_q.push_back(pack(part));
            part.delete();
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        base_valid = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #1;
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_base_ready", base_ready, 1'b1);
        chk("rst_word_out", word_out, '0);
        part.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] seq[6];
        rst        = 1'b1;
        base_in    = 2'b00;
        base_valid = 1'b0;
        word_ready = 1'b0;
        flush      = 1'b0;
        #3;
        chk("init_word_valid", word_valid, 1'b0);
        chk("init_base_ready", base_ready, 1'b1);
        chk("init_word_out", word_out, '0);
        do_reset();

        // Directed word 1,2,3,0,1,2
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        words = 0;
        for (int i = 0; i < 6; i++) cyc(1'b1, seq[i], 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("w939_count", words, 1);
        chk("w939_value", last_word, 12'h939);

        // Stall: 14 offered with word_ready low, only 12 accepted, then drain
        words = 0;
        n_acc = 0;
        for (int i = 0; i < 14; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("stall_acc", n_acc, 12);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("stall_words", words, 2);

        // 60 bases back-to-back with word_ready high
        words  = 0;
        br_low = 0;
        for (int i = 0; i < 60; i++) cyc(1'b1, 2'($urandom), 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("stream_words", words, 10);
        chk("stream_br_low", br_low, 0);

        // Reset mid-word, then six bases of 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'($urandom), 1'b1, 1'b0);
        do_reset();
        words = 0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'd3, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("rstmid_words", words, 1);
        chk("rstmid_value", last_word, 12'hFFF);

`ifdef DNA_PACK_FLUSH_EN
        words = 0;
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("flush_words", words, 1);
        chk("flush_value", last_word, 12'h00F);
        cyc(1'b0, 2'd0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("flush_empty_words", words, 1);
`endif

        // Random backpressure while streaming 120 bases
        words = 0;
        n_acc = 0;
        for (int i = 0; i < 3000 && n_acc < 120; i++) begin
            cyc(1'b1, 2'($urandom), 1'($urandom), 1'b0);
        end
        chk("rand_acc", n_acc, 120);
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("rand_words", words, 20);
        chk("rand_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
